// File: rtl/imm_extend_pipe.sv
// Immediate-extension unit for the MIPS decode stage: extends an IN_W-bit immediate
// (zero / sign / upper / branch) and queues the result with its tag in a DEPTH-entry FIFO.

module imm_ext #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  imm_i,
    input  logic [1:0]       mode_i,
    output logic [OUT_W-1:0] ext_o
);
    logic [OUT_W-1:0] zext, sext;

    assign zext = {{(OUT_W-IN_W){1'b0}}, imm_i};
    assign sext = {{(OUT_W-IN_W){imm_i[IN_W-1]}}, imm_i};

    always_comb begin
        ext_o = zext;
        case (mode_i)
            2'b00: ext_o = zext;
            2'b01: ext_o = sext;
            2'b10: ext_o = {imm_i, {(OUT_W-IN_W){1'b0}}};
            2'b11: ext_o = sext << 2;
            default: ext_o = zext;
        endcase
    end
endmodule

module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 5,
    parameter int CNT_W = 16,
    localparam int PW   = $clog2(DEPTH),
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic [LW-1:0]    level,
    output logic [CNT_W-1:0] accepted
);
    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [OUT_W-1:0] ext;
    logic             push, pop;
    entry_t           head;

    imm_ext #(.IN_W(IN_W), .OUT_W(OUT_W)) u_ext (
        .imm_i  (in_imm),
        .mode_i (in_mode),
        .ext_o  (ext)
    );

    // Handshake flags come only from registered occupancy, so no out_ready->in_ready path.
    assign in_ready  = (level_q != LW'(DEPTH));
    assign out_valid = (level_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign head      = mem_q[rd_ptr_q];
    assign out_data  = out_valid ? head.data : '0;
    assign out_tag   = out_valid ? head.tag  : '0;
    assign level     = level_q;
    assign accepted  = acc_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;
        acc_d    = acc_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
                acc_d    = acc_q + CNT_W'(1);
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            acc_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
            acc_q    <= acc_d;
        end
    end

    // Storage needs no reset: empty slots are masked at the output.
    always_ff @(posedge clk) begin
        if (!flush && push)
            mem_q[wr_ptr_q] <= '{data: ext, tag: in_tag};
    end
endmodule
